// File: rtl/galois_pow_sync_v4.sv
// Pipelined modular power unit: result = base^EXP mod MODULUS for EXP in {3,5,7}.
// Includes the synchronous interleaved modular multiplier it is built from.

module galois_mult_sync #(
    parameter int                N_BITS       = 254,
    parameter logic [N_BITS-1:0] MODULUS      = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                MULT_LATENCY = 13
) (
    input  logic              clk,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] p
);

    // Each pipeline stage folds BPS multiplier bits, MSB first, into a running residue.
    localparam int              BPS     = (N_BITS + MULT_LATENCY - 1) / MULT_LATENCY;
    localparam int              PW      = BPS * MULT_LATENCY;
    localparam logic [N_BITS:0] MOD_EXT = {1'b0, MODULUS};

    // NOTE: blocking assignments are correct here; t is a combinational temporary
    // inside a function, never state.
    function automatic logic [N_BITS-1:0] mac_bits(
        input logic [N_BITS-1:0] acc,
        input logic [N_BITS-1:0] x,
        input logic [BPS-1:0]    bits
    );
        logic [N_BITS:0] t;
        t = {1'b0, acc};
        for (int i = BPS - 1; i >= 0; i--) begin
            t = {t[N_BITS-1:0], 1'b0};
            if (t >= MOD_EXT) t = t - MOD_EXT;
            if (bits[i]) t = t + {1'b0, x};
            if (t >= MOD_EXT) t = t - MOD_EXT;
        end
        return t[N_BITS-1:0];
    endfunction

    logic [PW-1:0]     b_pad;
    logic [N_BITS-1:0] acc_q [MULT_LATENCY];
    logic [N_BITS-1:0] a_q   [MULT_LATENCY];
    logic [PW-1:0]     b_q   [MULT_LATENCY];

    assign b_pad = PW'(b);

    // NOTE: pure datapath registers carry no reset; validity is tracked elsewhere,
    // so resetting them would only cost area and reset-tree fanout.
    always_ff @(posedge clk) begin
        acc_q[0] <= mac_bits('0, a, b_pad[PW-1 -: BPS]);
        a_q[0]   <= a;
        b_q[0]   <= b_pad;
        for (int s = 1; s < MULT_LATENCY; s++) begin
            acc_q[s] <= mac_bits(acc_q[s-1], a_q[s-1], b_q[s-1][PW-1-s*BPS -: BPS]);
            a_q[s]   <= a_q[s-1];
            b_q[s]   <= b_q[s-1];
        end
    end

    assign p = acc_q[MULT_LATENCY-1];

endmodule

module galois_pow_sync_v4 #(
    parameter int                N_BITS       = 254,
    parameter logic [N_BITS-1:0] MODULUS      = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                EXP          = 7,
    parameter int                MULT_LATENCY = 13,
    parameter int                TAG_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [N_BITS-1:0]   base,
    input  logic [TAG_BITS-1:0] in_tag,
    input  logic                flush,
    output logic                out_valid,
    output logic [N_BITS-1:0]   result,
    output logic [TAG_BITS-1:0] out_tag
);

    localparam int DEPTH   = (EXP == 3) ? 2 : 3;
    localparam int LATENCY = DEPTH * MULT_LATENCY;
    // x is needed one multiplier later for EXP 3/7, two multipliers later for EXP 5.
    localparam int X_DEPTH = (EXP == 5) ? 2 * MULT_LATENCY : MULT_LATENCY;

    if (EXP != 3 && EXP != 5 && EXP != 7) begin : g_bad_exp
        $error("galois_pow_sync_v4: EXP=%0d is not supported (legal: 3, 5, 7)", EXP);
    end

    logic [N_BITS-1:0] x_sr [X_DEPTH];

    always_ff @(posedge clk) begin
        x_sr[0] <= base;
        for (int i = 1; i < X_DEPTH; i++) x_sr[i] <= x_sr[i-1];
    end

    logic [N_BITS-1:0] s1;

    galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_sq (
        .clk (clk),
        .a   (base),
        .b   (base),
        .p   (s1)
    );

    if (EXP == 3) begin : g_exp3
        galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_m2 (
            .clk (clk),
            .a   (s1),
            .b   (x_sr[MULT_LATENCY-1]),
            .p   (result)
        );
    end else if (EXP == 5) begin : g_exp5
        logic [N_BITS-1:0] s2;
        galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_m2 (
            .clk (clk),
            .a   (s1),
            .b   (s1),
            .p   (s2)
        );
        galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_m3 (
            .clk (clk),
            .a   (s2),
            .b   (x_sr[2*MULT_LATENCY-1]),
            .p   (result)
        );
    end else begin : g_exp7
        // x^3 and x^4 are formed side by side so x^7 costs only three multiplier depths.
        logic [N_BITS-1:0] cube;
        logic [N_BITS-1:0] quad;
        galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_m2a (
            .clk (clk),
            .a   (s1),
            .b   (x_sr[MULT_LATENCY-1]),
            .p   (cube)
        );
        galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_m2b (
            .clk (clk),
            .a   (s1),
            .b   (s1),
            .p   (quad)
        );
        galois_mult_sync #(.N_BITS(N_BITS), .MODULUS(MODULUS), .MULT_LATENCY(MULT_LATENCY)) u_m3 (
            .clk (clk),
            .a   (cube),
            .b   (quad),
            .p   (result)
        );
    end

    logic [LATENCY-1:0]  vld_sr;
    logic [TAG_BITS-1:0] tag_sr [LATENCY];

    // Flush wipes every in-flight valid, including the operand arriving this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vld_sr <= '0;
        else if (flush) vld_sr <= '0;
        else            vld_sr <= {vld_sr[LATENCY-2:0], in_valid};
    end

    always_ff @(posedge clk) begin
        tag_sr[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
    end

    assign out_valid = vld_sr[LATENCY-1];
    assign out_tag   = tag_sr[LATENCY-1];

endmodule

// File: tb/tb_galois_pow_sync_v4.sv
// Scoreboard bench for galois_pow_sync_v4 driving EXP=7, 5 and 3 instances in lockstep.

module tb_galois_pow_sync_v4;

    localparam int            N    = 254;
    localparam logic [N-1:0]  M    = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int            ML   = 13;
    localparam int            LAT7 = 3 * ML;
    localparam int            LAT5 = 3 * ML;
    localparam int            LAT3 = 2 * ML;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         in_valid = 1'b0;
    logic         flush    = 1'b0;
    logic [N-1:0] base     = '0;
    logic [7:0]   in_tag   = '0;

    logic         ov7, ov5, ov3;
    logic [N-1:0] r7, r5, r3;
    logic [7:0]   t7, t5, t3;

    galois_pow_sync_v4 #(.EXP(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .base(base), .in_tag(in_tag),
        .flush(flush), .out_valid(ov7), .result(r7), .out_tag(t7)
    );
    galois_pow_sync_v4 #(.EXP(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .base(base), .in_tag(in_tag),
        .flush(flush), .out_valid(ov5), .result(r5), .out_tag(t5)
    );
    galois_pow_sync_v4 #(.EXP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .base(base), .in_tag(in_tag),
        .flush(flush), .out_valid(ov3), .result(r3), .out_tag(t3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [7:0]   tag;
        logic [N-1:0] res;
    } exp_t;

    exp_t q7[$];
    exp_t q5[$];
    exp_t q3[$];
    exp_t empty_e = '{due: 0, tag: 8'h00, res: '0};
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   armed    = 1'b0;

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] wa, wb, wm, pr;
        wa = {{N{1'b0}}, a};
        wb = {{N{1'b0}}, b};
        wm = {{N{1'b0}}, M};
        pr = (wa * wb) % wm;
        return pr[N-1:0];
    endfunction

    function automatic logic [N-1:0] powmod(input logic [N-1:0] x, input int e);
        logic [N-1:0] r;
        r = 1;
        for (int i = 0; i < e; i++) r = mulmod(r, x);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [255:0] w;
        logic [N-1:0] v;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        v = w[N-1:0];
        if (v >= M) v = v - M;
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // Golden model: capture side mirrors what the consumer should see, cycle-accurately.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q7.delete(); q5.delete(); q3.delete();
        end else begin
            cyc++;
            if (flush) begin
                q7.delete(); q5.delete(); q3.delete();
            end else if (in_valid) begin
                q7.push_back('{due: cyc + LAT7 - 1, tag: in_tag, res: powmod(base, 7)});
                q5.push_back('{due: cyc + LAT5 - 1, tag: in_tag, res: powmod(base, 5)});
                q3.push_back('{due: cyc + LAT3 - 1, tag: in_tag, res: powmod(base, 3)});
            end
        end
    end

    task automatic mon_one(input string nm, input logic ov, input logic [N-1:0] r,
                           input logic [7:0] t, input bit have, input exp_t head,
                           output bit pop);
        bit exp_v;
        exp_v = have && (head.due == cyc);
        chk({nm, "_valid"}, N'(ov), N'(exp_v));
        if (exp_v) begin
            chk({nm, "_result"}, r, head.res);
            chk({nm, "_tag"}, N'(t), N'(head.tag));
        end
        pop = have && (head.due <= cyc);
    endtask

    always @(negedge clk) begin
        bit p;
        if (armed) begin
            mon_one("e7", ov7, r7, t7, q7.size() > 0, (q7.size() > 0) ? q7[0] : empty_e, p);
            if (p) void'(q7.pop_front());
            mon_one("e5", ov5, r5, t5, q5.size() > 0, (q5.size() > 0) ? q5[0] : empty_e, p);
            if (p) void'(q5.pop_front());
            mon_one("e3", ov3, r3, t3, q3.size() > 0, (q3.size() > 0) ? q3[0] : empty_e, p);
            if (p) void'(q3.pop_front());
        end
    end

    task automatic drive(input logic v, input logic [N-1:0] b, input logic [7:0] t, input logic f);
        in_valid = v;
        base     = b;
        in_tag   = t;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 8'h00, 1'b0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ov7", N'(ov7), '0);
        chk("reset_ov5", N'(ov5), '0);
        chk("reset_ov3", N'(ov3), '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        armed = 1'b1;
        @(posedge clk);
        #1;

        // Directed back-to-back operands.
        drive(1'b1, 2, 8'h01, 1'b0);
        drive(1'b1, 1, 8'h02, 1'b0);
        drive(1'b1, 0, 8'h03, 1'b0);
        idle(LAT7 + 4);

        // Boundary operand MODULUS-1 and base 3.
        drive(1'b1, M - 1, 8'h10, 1'b0);
        drive(1'b0, '0, 8'h00, 1'b0);
        drive(1'b1, 3, 8'h11, 1'b0);
        idle(LAT7 + 4);

        // Streaming with ~30% gaps.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(99) < 30) drive(1'b0, rand_op(), 8'(i), 1'b0);
            else                         drive(1'b1, rand_op(), 8'(i), 1'b0);
        end
        idle(LAT7 + 4);

        // Flush on the 6th of 10 consecutive captures.
        for (int i = 1; i <= 10; i++) drive(1'b1, rand_op(), 8'(8'h80 + i), (i == 6));
        idle(LAT7 + 4);

        // Asynchronous reset while 20 operands are in flight.
        for (int i = 0; i < 20; i++) drive(1'b1, rand_op(), 8'(8'hA0 + i), 1'b0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ov7", N'(ov7), '0);
        chk("midrst_ov5", N'(ov5), '0);
        chk("midrst_ov3", N'(ov3), '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, rand_op(), 8'(8'hC0 + i), 1'b0);
        idle(LAT7 + 4);

        for (int i = 0; i < 60 && (q7.size() + q5.size() + q3.size()) != 0; i++) idle(1);
        chk("drain_q7", N'(q7.size()), '0);
        chk("drain_q5", N'(q5.size()), '0);
        chk("drain_q3", N'(q3.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
